// File: rtl/ff256_pkg.sv
// Shared constants for the GF(256) vector MAC: register map, CTRL/STAT bits,
// FSM state encoding and the default reduction polynomial.
package ff256_pkg;

  localparam int ADDR_CTRL = 0;
  localparam int ADDR_COEF = 1;
  localparam int ADDR_DATA = 2;
  localparam int ADDR_ACC  = 3;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_CLEAR = 1;
  localparam int CTRL_IE    = 2;

  // STAT read bits (IE reads back at CTRL_IE)
  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;

  // Low byte of x^8 + x^4 + x^3 + x + 1
  localparam logic [7:0] POLY_DEFAULT = 8'h1B;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ff256_gf_mul.sv
// Combinational GF(2^8) multiplier; poly is the low byte of the monic
// degree-8 reduction polynomial.
module ff256_gf_mul (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic [7:0] poly,
  output logic [7:0] product
);

  logic [7:0] a_sh;

  // Shift-and-add, reducing a*x^i as it is formed so nothing exceeds 8 bits
  always_comb begin
    product = '0;
    a_sh    = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) product = product ^ a_sh;
      a_sh = a_sh[7] ? ({a_sh[6:0], 1'b0} ^ poly) : {a_sh[6:0], 1'b0};
    end
  end

endmodule

// File: rtl/ff256_vec_mac.sv
// Wishbone-attached GF(256) per-lane multiply-accumulate with input FIFO.
// Define FF256_VEC_MAC_POLY_EN to make the reduction polynomial writable at CTRL[15:8].
//
//  state | meaning
//  IDLE  | waiting for START; pushes still fill the FIFO
//  RUN   | popping one word per cycle into the multiply pipeline
//  DRAIN | START written 0; finishing queued words, then sets done
module ff256_vec_mac
  import ff256_pkg::*;
#(
  parameter int BUS_WIDTH  = 2,
  parameter int DATA_WIDTH = 32,
  parameter int BE_WIDTH   = 4,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BUS_WIDTH-1:0]  adr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  we_i,
  input  logic [BE_WIDTH-1:0]   sel_i,
  input  logic                  stb_i,
  input  logic                  cyc_i,
  output logic                  ack_o,
  output logic                  irq_o
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam int AW    = $clog2(DEPTH);

  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] coef, acc, prod, prod_comb, head;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW:0]           wr_ptr, rd_ptr, level;
  logic [7:0]            level8, poly;
  logic [15:0]           count;
  logic                  empty, full, pop, push, prod_vld;
  logic                  done, ie, busy, done_set;
  logic                  req, ack_nxt, wr_ok;
  logic                  is_ctrl, is_coef, is_data, is_acc;
  logic                  ctrl_wr, start_wr, stop_wr, clear_wr;

  assign is_ctrl = (adr_i == BUS_WIDTH'(ADDR_CTRL));
  assign is_coef = (adr_i == BUS_WIDTH'(ADDR_COEF));
  assign is_data = (adr_i == BUS_WIDTH'(ADDR_DATA));
  assign is_acc  = (adr_i == BUS_WIDTH'(ADDR_ACC));

  // A DATA write into a full FIFO waits; the ack follows once a pop frees a slot
  assign req     = stb_i & cyc_i & ~ack_o;
  assign ack_nxt = req & ~(we_i & is_data & full);
  assign wr_ok   = ack_nxt & we_i;

  assign ctrl_wr  = wr_ok & is_ctrl & sel_i[0];
  assign start_wr = ctrl_wr & data_i[CTRL_START];
  assign stop_wr  = ctrl_wr & ~data_i[CTRL_START];
  assign clear_wr = ctrl_wr & data_i[CTRL_CLEAR];
  assign push     = wr_ok & is_data;

  assign level  = wr_ptr - rd_ptr;
  assign level8 = 8'(level);
  assign empty  = (level == '0);
  assign full   = (level == (AW + 1)'(DEPTH));
  assign head   = mem[rd_ptr[AW-1:0]];

  assign busy  = (state != ST_IDLE) | ~empty | prod_vld;
  assign irq_o = done & ie;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    ff256_gf_mul u_mul (
      .a       (coef[g*8 +: 8]),
      .b       (head[g*8 +: 8]),
      .poly    (poly),
      .product (prod_comb[g*8 +: 8])
    );
  end

`ifdef FF256_VEC_MAC_POLY_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                       poly <= POLY_DEFAULT;
    else if (wr_ok & is_ctrl & sel_i[1]) poly <= data_i[15:8];
  end
`else
  assign poly = POLY_DEFAULT;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done_set  = 1'b0;
    case (state)
      ST_IDLE: if (start_wr) state_nxt = ST_RUN;
      ST_RUN: begin
        pop = ~empty;
        if (stop_wr) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        pop = ~empty;
        if (start_wr) state_nxt = ST_RUN;
        else if (empty && !prod_vld) begin
          state_nxt = ST_IDLE;
          done_set  = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (clear_wr) begin
      state_nxt = ST_IDLE;
      pop       = 1'b0;
      done_set  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      ack_o    <= 1'b0;
      coef     <= '0;
      acc      <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      done     <= 1'b0;
      ie       <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_o <= ack_nxt;
      if (ctrl_wr) ie <= data_i[CTRL_IE];
      for (int i = 0; i < LANES; i++) begin
        if (wr_ok && is_coef && sel_i[i]) coef[i*8 +: 8] <= data_i[i*8 +: 8];
      end
      if (clear_wr) begin
        acc      <= '0;
        count    <= '0;
        done     <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        prod_vld <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        prod_vld <= pop;
        if (pop) prod <= prod_comb;
        if (prod_vld) begin
          acc <= acc ^ prod;
          if (count != 16'hFFFF) count <= count + 16'd1;
        end
        if (start_wr)      done <= 1'b0;
        else if (done_set) done <= 1'b1;
      end
    end
  end

  // FIFO storage needs no reset; the pointers define what is valid
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= data_i;
  end

  always_comb begin
    data_o = '0;
    if (is_ctrl) begin
      data_o[STAT_BUSY] = busy;
      data_o[STAT_DONE] = done;
      data_o[CTRL_IE]   = ie;
`ifdef FF256_VEC_MAC_POLY_EN
      data_o[15:8]      = poly;
`else
      data_o[15:8]      = level8;
`endif
      data_o[31:16]     = count;
    end else if (is_coef) begin
      data_o = coef;
    end else if (is_acc) begin
      data_o = acc;
    end
  end

endmodule

// File: doc/ff256_vec_mac.md
FF256_VEC_MAC -- requirements
Module: ff256_vec_mac

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 2: Wishbone word-address width; only addresses 0-3 are decoded.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: bus width; LANES = DATA_WIDTH/8 GF(256) byte lanes.
REQ-003 SHALL have parameter BE_WIDTH, default 4: byte-select width, equal to LANES.
REQ-004 SHALL have parameter DEPTH, default 8: input FIFO depth in words, a power of 2, at least 2.
REQ-005 SHALL have the following ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- adr_i  in  BUS_WIDTH  word address
- data_i  in  DATA_WIDTH  write data
- data_o  out  DATA_WIDTH  read data
- we_i  in  1  write enable
- sel_i  in  BE_WIDTH  byte selects
- stb_i  in  1  strobe
- cyc_i  in  1  cycle
- ack_o  out  1  acknowledge
- irq_o  out  1  level interrupt: done AND ie

Function
REQ-006 SHALL decode the following register map:
- 0: CTRL/STAT. Write bit0 START, bit1 CLEAR (self-clearing), bit2 IE. Read: bit0 busy, bit1 done, bit2 IE, bits[15:8] FIFO level, bits[31:16] word count.
- 1: COEF, per-lane coefficient, byte-writable via sel_i.
- 2: DATA, push to FIFO on write; reads 0.
- 3: ACC, per-lane accumulator, read-only.
REQ-007 SHALL register ack_o: it asserts for exactly 1 cycle, 1 cycle after stb_i&cyc_i with ack_o low; the write takes effect on that same edge.
REQ-008 SHALL hold off ack_o for a DATA write while the FIFO is full (wait states), and SHALL ack it in the cycle after a slot frees; words are never dropped.
REQ-009 SHALL drive data_o combinationally from adr_i; unmapped bits read 0.
REQ-010 SHALL implement a state machine:
- IDLE -> RUN on START.
- RUN pops one word per cycle while the FIFO is non-empty.
- RUN -> DRAIN when START is written 0.
- DRAIN -> IDLE when the FIFO and pipeline are empty; this sets done.
REQ-011 SHALL pipeline each pop as follows: cycle t pop; t+1 product register, prod[i] = coef[i] GF* data[i]; t+2 acc[i] ^= prod[i], count increments.
REQ-012 SHALL saturate count at 0xFFFF.
REQ-013 SHALL use coefficient values sampled at pop time; a COEF write in the same cycle takes effect from the next pop.
REQ-014 On CLEAR, SHALL zero acc, count and done, and SHALL flush the FIFO and pipeline. CLEAR wins over a simultaneous pop or push, and over in-flight products. The state returns to IDLE.
REQ-015 SHALL assert busy when the state is not IDLE, or when the FIFO or pipeline is non-empty.
REQ-016 SHALL clear done on a START write.
REQ-017 Simultaneous push and pop at full or empty SHALL leave the level correct, with no overflow or underflow. FIFO pointers SHALL wrap modulo DEPTH.

Reset
REQ-018 On reset low SHALL clear:
- all registers, the FIFO pointers and the pipeline valids;
- state to IDLE;
- ack_o = 0, irq_o = 0, data_o = 0 for address 0.
REQ-019 Reset asserted mid-operation SHALL abandon in-flight words with no partial accumulation after release.

Configuration
REQ-020 With FF256_VEC_MAC_POLY_EN defined, SHALL add writable CTRL bits[15:8], the low 8 bits of the reduction polynomial x^8+p, reset 0x1B; these bits read back the polynomial.
REQ-021 Without FF256_VEC_MAC_POLY_EN, SHALL use the fixed polynomial 0x11B and keep CTRL bits[15:8] read-only as FIFO level.

Structure
REQ-022 SHALL place register address constants, CTRL/STAT bit indices, state encodings and the default polynomial in shared package ff256_pkg.
REQ-023 SHALL instantiate LANES copies of combinational sub-module ff256_gf_mul (a, b, poly -> product).
REQ-024 SHALL keep the FIFO inline, not as a separate module.

Verification
REQ-025 Single-word check: COEF=0x53_02_01_00, DATA=0xCA_87_FF_12, START, then STOP. Expected: ACC=0x01_15_FF_00, count=1, done=1.
REQ-026 Accumulation check: write DATA 0x01010101 then 0x02020202 with COEF=0x03030303. Expected: ACC=0x05050505 (0x03 ^ 0x06 in each lane).
REQ-027 Backpressure check: with START=0, push DEPTH+1 words. Expected: the final ack is withheld and level=DEPTH. Then START. Expected: the held word is acked and all DEPTH+1 words are accumulated.
REQ-028 CLEAR check: write CLEAR while RUN has 3 words queued. Expected: acc=0, count=0, level=0, state IDLE, and no later ACC change.
REQ-029 Reset check: assert reset mid-RUN. Expected: all readback 0 and irq_o=0. IE=1 with done set -> irq_o=1 until START.
REQ-030 Polynomial check (FF256_VEC_MAC_POLY_EN only): poly=0x1D, 0x80*0x02 -> 0x1D.
